// File: rtl/recv_fifo_uart_tx.sv
// Receive-domain FIFO drain: pops one byte at a time and shifts it out as an
// 8N1-style UART frame (start 0, data LSB first, stop 1) on tx_serial.
module recv_fifo_uart_tx #(
  parameter int data_bus_length = 8,
  parameter int clks_per_bit    = 16,
  parameter int count_width     = 16
) (
  input  logic                       recv_clk,
  input  logic                       recv_rst,
  input  logic                       fifo_empty,
  input  logic [data_bus_length-1:0] recv_data,
  output logic                       read_enable,
  input  logic                       tx_enable,
  output logic                       tx_serial,
  output logic                       tx_busy,
  output logic [count_width-1:0]     byte_count
);

  localparam int baud_width = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int bit_width  = (data_bus_length > 1) ? $clog2(data_bus_length) : 1;
  localparam logic [baud_width-1:0] baud_last = baud_width'(clks_per_bit - 1);
  localparam logic [bit_width-1:0]  bit_last  = bit_width'(data_bus_length - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

  state_t                     state, state_next;
  logic [data_bus_length-1:0] shift_reg, shift_next;
  logic [baud_width-1:0]      baud_cnt, baud_next;
  logic [bit_width-1:0]       bit_idx, bit_next;
  logic                       read_enable_next, tx_serial_next, tx_busy_next;
  logic [count_width-1:0]     byte_count_next;

  // Every output is a flop; the comb block below computes each one's next value.
  always_ff @(posedge recv_clk or negedge recv_rst) begin
    if (!recv_rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      read_enable <= 1'b0;
      tx_serial   <= 1'b1;
      tx_busy     <= 1'b0;
      byte_count  <= '0;
    end else begin
      state       <= state_next;
      shift_reg   <= shift_next;
      baud_cnt    <= baud_next;
      bit_idx     <= bit_next;
      read_enable <= read_enable_next;
      tx_serial   <= tx_serial_next;
      tx_busy     <= tx_busy_next;
      byte_count  <= byte_count_next;
    end
  end

  // The line level for the next bit is chosen at the boundary edge, so
  // tx_serial changes exactly when the state/bit changes.
  always_comb begin
    state_next       = state;
    shift_next       = shift_reg;
    baud_next        = baud_cnt;
    bit_next         = bit_idx;
    read_enable_next = 1'b0;
    tx_serial_next   = tx_serial;
    byte_count_next  = byte_count;

    case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) begin
          state_next       = POP;
          read_enable_next = 1'b1;
        end
      end
      POP: state_next = LOAD;
      LOAD: begin
        state_next     = START;
        shift_next     = recv_data;
        baud_next      = '0;
        tx_serial_next = 1'b0;
      end
      START: begin
        if (baud_cnt == baud_last) begin
          state_next     = DATA;
          baud_next      = '0;
          bit_next       = '0;
          tx_serial_next = shift_reg[0];
          shift_next     = shift_reg >> 1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_cnt == baud_last) begin
          baud_next = '0;
          if (bit_idx == bit_last) begin
            state_next     = STOP;
            tx_serial_next = 1'b1;
          end else begin
            bit_next       = bit_idx + 1'b1;
            tx_serial_next = shift_reg[0];
            shift_next     = shift_reg >> 1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        if (baud_cnt == baud_last) begin
          state_next      = IDLE;
          baud_next       = '0;
          byte_count_next = byte_count + 1'b1;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    tx_busy_next = (state_next != IDLE);
  end

endmodule

// File: tb/tb_recv_fifo_uart_tx.sv
// Bench for recv_fifo_uart_tx with clks_per_bit=4 and count_width=4: a frame-timing
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_recv_fifo_uart_tx;

  localparam int C         = 4;
  localparam int FRAME_END = 2 + 10 * C;

  logic       recv_clk = 1'b0;
  logic       recv_rst = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] recv_data = 8'h00;
  logic       read_enable;
  logic       tx_enable = 1'b0;
  logic       tx_serial;
  logic       tx_busy;
  logic [3:0] byte_count;

  recv_fifo_uart_tx #(
    .data_bus_length(8),
    .clks_per_bit(C),
    .count_width(4)
  ) dut (
    .recv_clk(recv_clk),
    .recv_rst(recv_rst),
    .fifo_empty(fifo_empty),
    .recv_data(recv_data),
    .read_enable(read_enable),
    .tx_enable(tx_enable),
    .tx_serial(tx_serial),
    .tx_busy(tx_busy),
    .byte_count(byte_count)
  );

  always #5 recv_clk = ~recv_clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];

  logic       m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_byte   = 8'h00;
  logic [3:0] m_count  = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  always @(posedge recv_clk) cyc++;

  // FIFO read port: data appears after the popping edge, empty flag follows the queue.
  always @(negedge recv_clk) begin
    if (read_enable === 1'b1 && fifo_q.size() > 0) recv_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  end

  // Frame model: m_t counts cycles since the edge that entered POP.
  always @(posedge recv_clk or negedge recv_rst) begin
    if (!recv_rst) begin
      m_active = 1'b0;
      m_t      = 0;
      m_count  = 4'd0;
    end else if (m_active) begin
      m_t++;
      if (m_t == FRAME_END) begin
        m_active = 1'b0;
        m_count++;
      end
    end else if (tx_enable && !fifo_empty) begin
      check("model has a byte to send", exp_q.size() > 0, 1);
      m_active = 1'b1;
      m_t      = 0;
      if (exp_q.size() > 0) m_byte = exp_q.pop_front();
    end
  end

  always @(negedge recv_clk) begin
    logic exp_tx;
    int   idx;
    exp_tx = 1'b1;
    if (m_active && m_t >= 2 && m_t < 2 + C) exp_tx = 1'b0;
    else if (m_active && m_t >= 2 + C && m_t < 2 + 9 * C) begin
      idx    = (m_t - 2) / C - 1;
      exp_tx = m_byte[idx];
    end
    check("model read_enable", read_enable, m_active && m_t == 0);
    check("model tx_busy", tx_busy, m_active);
    check("model tx_serial", tx_serial, exp_tx);
    check("model byte_count", byte_count, m_count);
  end

  task automatic wait_pop(input string tag, output int at);
    at = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge recv_clk);
      if (read_enable === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check({tag, " pop seen within bound"}, at >= 0, 1);
  endtask

  task automatic count_pops(input int n_cycles, output int pops);
    pops = 0;
    for (int n = 0; n < n_cycles; n++) begin
      @(negedge recv_clk);
      if (read_enable === 1'b1) pops++;
    end
  endtask

  task automatic applyStimulus();
    int         at, prev, pops;
    logic [9:0] want;

    // Reset held with data waiting and enable high.
    tx_enable = 1'b1;
    push(8'd17);
    repeat (2) begin
      @(negedge recv_clk);
      check("reset tx_serial", tx_serial, 1);
      check("reset read_enable", read_enable, 0);
      check("reset tx_busy", tx_busy, 0);
      check("reset byte_count", byte_count, 0);
    end
    recv_rst = 1'b1;
    @(negedge recv_clk);
    check("first pop one cycle after release", read_enable, 1);

    // Single byte 17: sample each of the 10 bit cells mid-cell.
    want = 10'b1_00010001_0;
    repeat (3) @(negedge recv_clk);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("byte17 bit cell %0d", j), tx_serial, want[j]);
      repeat (C) @(negedge recv_clk);
    end
    check("single byte_count", byte_count, 1);
    check("single tx_busy after", tx_busy, 0);

    // Burst of 16 bytes back-to-back.
    for (int b = 17; b <= 32; b++) push(8'(b));
    prev = -1;
    for (int i = 0; i < 16; i++) begin
      wait_pop($sformatf("burst %0d", i), at);
      if (i > 0) check("burst pop spacing", at - prev, 43);
      prev = at;
    end
    count_pops(250, pops);
    check("burst no pop after empty", pops, 0);
    check("burst byte_count wrapped", byte_count, 1);

    // Flow gate: drop enable during data of byte 20.
    push(8'd20);
    push(8'd21);
    wait_pop("gate", at);
    repeat (2 + 3 * C) @(negedge recv_clk);
    tx_enable = 1'b0;
    count_pops(150, pops);
    check("gate no pop while disabled", pops, 0);
    check("gate byte_count after frame", byte_count, 2);
    tx_enable = 1'b1;
    @(negedge recv_clk);
    check("gate pop one cycle after enable", read_enable, 1);
    repeat (FRAME_END + 3) @(negedge recv_clk);
    check("gate byte_count", byte_count, 3);

    // Reset mid-frame during data bit 3 of A5.
    push(8'hA5);
    push(8'h3C);
    wait_pop("midreset", at);
    repeat (2 + 4 * C + 1) @(negedge recv_clk);
    check("A5 bit3 low before reset", tx_serial, 0);
    #1 recv_rst = 1'b0;
    #1;
    check("midreset tx_serial async high", tx_serial, 1);
    check("midreset byte_count", byte_count, 0);
    check("midreset tx_busy", tx_busy, 0);
    @(negedge recv_clk);
    recv_rst = 1'b1;
    wait_pop("after reset", at);
    repeat (FRAME_END + 3) @(negedge recv_clk);
    check("after reset byte_count", byte_count, 1);

    // Long empty idle, then 17 bytes to wrap the 4-bit counter.
    recv_rst = 1'b0;
    @(negedge recv_clk);
    recv_rst = 1'b1;
    pops = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge recv_clk);
      if (read_enable === 1'b1) pops++;
      if (n % 50 == 0) check("idle tx_serial high", tx_serial, 1);
    end
    check("idle no pops", pops, 0);
    for (int b = 0; b < 17; b++) push(8'h40 + 8'(b));
    for (int i = 0; i < 17; i++) wait_pop($sformatf("wrap %0d", i), at);
    repeat (FRAME_END + 3) @(negedge recv_clk);
    checkOutput(4'd1);
  endtask

  task automatic checkOutput(input logic [3:0] want_count);
    check("wrap byte_count", byte_count, want_count);
    check("wrap tx_busy idle", tx_busy, 0);
    check("wrap tx_serial idle", tx_serial, 1);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
